// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Handles load-use bubbles and multi-cycle data-memory waits with timeout.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  rsD,
   input  logic [5:0]  rtD,
   input  logic [5:0]  WriteRegE,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemtoRegM,
   input  logic        MemWriteM,
   input  logic        mem_ready,
   output logic        enable_pc,
   output logic        enable_if_id,
   output logic        enable_id_ex,
   output logic        enable_ex_mem,
   output logic        enable_mem_wb,
   output logic        flush_id_ex,
   output logic        mem_req,
   output logic        mem_error,
   output logic [15:0] stall_cnt
);

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_nxt;

   logic mem_acc;
   logic lu_haz;
   logic freeze;

   assign mem_acc = MemtoRegM | MemWriteM;

   // Register 0 is hard-wired, so it never creates a dependency.
   assign lu_haz = RegWriteE & MemtoRegE & (WriteRegE != 6'd0)
                 & ((WriteRegE == rsD) | (WriteRegE == rtD));

   assign freeze = ((state == RUN) & mem_acc & ~mem_ready)
                 | ((state == MEM_WAIT) & ~mem_ready);

   // State and wait counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Next-state logic; a ready on the timeout cycle still wins.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      unique case (state)
         RUN: begin
            if (mem_acc && !mem_ready) begin
               state_nxt = MEM_WAIT;
               wait_nxt  = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt = RUN;
               wait_nxt  = 8'd0;
            end else if (wait_cnt == TMO) begin
               state_nxt = ERROR;
            end else begin
               wait_nxt = wait_cnt + 8'd1;
            end
         end
         ERROR: begin
            state_nxt = ERROR;
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = 8'd0;
         end
      endcase
   end

   // Enables and flush: reset, error, freeze, load-use, then run.
   always_comb begin
      enable_pc     = 1'b0;
      enable_if_id  = 1'b0;
      enable_id_ex  = 1'b0;
      enable_ex_mem = 1'b0;
      enable_mem_wb = 1'b0;
      flush_id_ex   = 1'b0;
      mem_req       = 1'b0;
      if (reset) begin
         mem_req = 1'b0;
      end else if (state == ERROR) begin
         mem_req = 1'b0;
      end else begin
         mem_req = mem_acc;
         if (freeze) begin
            flush_id_ex = 1'b0;
         end else if (lu_haz) begin
            enable_id_ex  = 1'b1;
            enable_ex_mem = 1'b1;
            enable_mem_wb = 1'b1;
            flush_id_ex   = 1'b1;
         end else begin
            enable_pc     = 1'b1;
            enable_if_id  = 1'b1;
            enable_id_ex  = 1'b1;
            enable_ex_mem = 1'b1;
            enable_mem_wb = 1'b1;
         end
      end
   end

   // Sticky fault flag, raised on the edge that enters ERROR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_error <= 1'b0;
      end else if (state_nxt == ERROR) begin
         mem_error <= 1'b1;
      end
   end

   // Saturating count of cycles with the PC held, excluding ERROR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 16'd0;
      end else if (!enable_pc && state != ERROR
                   && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with MEM_TIMEOUT = 4.
// Expected values come from a small behavioural model of the controller.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  rsD, rtD, WriteRegE;
   logic        RegWriteE, MemtoRegE, MemtoRegM, MemWriteM, mem_ready;
   logic        enable_pc, enable_if_id, enable_id_ex;
   logic        enable_ex_mem, enable_mem_wb, flush_id_ex;
   logic        mem_req, mem_error;
   logic [15:0] stall_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0]  ctl;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   // reference model state: 0 RUN, 1 MEM_WAIT, 2 ERROR
   int m_st = 0;
   int m_wait = 0;
   bit m_err = 1'b0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk),
      .reset(reset),
      .rsD(rsD),
      .rtD(rtD),
      .WriteRegE(WriteRegE),
      .RegWriteE(RegWriteE),
      .MemtoRegE(MemtoRegE),
      .MemtoRegM(MemtoRegM),
      .MemWriteM(MemWriteM),
      .mem_ready(mem_ready),
      .enable_pc(enable_pc),
      .enable_if_id(enable_if_id),
      .enable_id_ex(enable_id_ex),
      .enable_ex_mem(enable_ex_mem),
      .enable_mem_wb(enable_mem_wb),
      .flush_id_ex(flush_id_ex),
      .mem_req(mem_req),
      .mem_error(mem_error),
      .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_reset(input logic r);
      reset = r;
      if (r) begin
         m_st = 0;
         m_wait = 0;
         m_err = 1'b0;
         m_cnt = 0;
      end
   endtask

   // Drive one cycle, predict, compare at negedge, advance model at posedge.
   task automatic cyc(input string tag,
                      input logic [5:0] rs, input logic [5:0] rt,
                      input logic [5:0] wr, input logic rw,
                      input logic mre, input logic mrm,
                      input logic mwm, input logic rdy);
      logic acc, lu, frz, req, fl;
      logic [4:0] en;
      exp_t e, o;
      rsD = rs; rtD = rt; WriteRegE = wr;
      RegWriteE = rw; MemtoRegE = mre;
      MemtoRegM = mrm; MemWriteM = mwm; mem_ready = rdy;
      acc = mrm | mwm;
      lu = rw && mre && (wr != 0) && (wr == rs || wr == rt);
      frz = (m_st == 0 && acc && !rdy) || (m_st == 1 && !rdy);
      en = 5'b00000;
      fl = 1'b0;
      req = 1'b0;
      if (!reset && m_st != 2) begin
         req = acc;
         if (frz) en = 5'b00000;
         else if (lu) begin en = 5'b00111; fl = 1'b1; end
         else en = 5'b11111;
      end
      e.ctl = {en, fl, req, m_err};
      e.cnt = 16'(m_cnt);
      sb.push_back(e);
      @(negedge clk);
      o.ctl = {enable_pc, enable_if_id, enable_id_ex, enable_ex_mem,
               enable_mem_wb, flush_id_ex, mem_req, mem_error};
      o.cnt = stall_cnt;
      e = sb.pop_front();
      chk({tag, ".ctl"}, 32'(o.ctl), 32'(e.ctl));
      chk({tag, ".cnt"}, 32'(o.cnt), 32'(e.cnt));
      @(posedge clk);
      if (!reset) begin
         if (!en[4] && m_st != 2 && m_cnt < 65535) m_cnt++;
         case (m_st)
            0: if (acc && !rdy) begin m_st = 1; m_wait = 1; end
            1: begin
               if (rdy) begin m_st = 0; m_wait = 0; end
               else if (m_wait == 4) begin m_st = 2; m_err = 1'b1; end
               else m_wait++;
            end
            default: ;
         endcase
      end
      #1;
   endtask

   task automatic idle(input string tag);
      cyc(tag, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rsD = 0; rtD = 0; WriteRegE = 0;
      RegWriteE = 0; MemtoRegE = 0;
      MemtoRegM = 0; MemWriteM = 0; mem_ready = 0;
      set_reset(1'b1);
      #1;
      idle("rst0");
      idle("rst1");
      set_reset(1'b0);
      idle("run");

      // load-use on rs
      cyc("lu", 6'd5, 6'd0, 6'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle("lu_after");
      @(negedge clk);
      chk("lu_cnt_abs", 32'(stall_cnt), 32'd1);
      @(posedge clk); #1;

      // load-use on rt
      cyc("lu_rt", 6'd7, 6'd9, 6'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // register 0 never hazards
      cyc("r0", 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("r0b", 6'd3, 6'd0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // not a load: no stall
      cyc("nold", 6'd5, 6'd0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // memory wait, ready after 3 cycles
      for (int i = 0; i < 3; i++)
         cyc("mw", 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("mw_rdy", 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle("mw_after");

      // ready on first cycle: no stall
      cyc("rdy0", 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

      // ready with no access is ignored
      cyc("rdy_na", 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // ready exactly on the timeout boundary
      for (int i = 0; i < 4; i++)
         cyc("bnd", 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("bnd_rdy", 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle("bnd_after");
      @(negedge clk);
      chk("bnd_err_abs", 32'(mem_error), 32'd0);
      @(posedge clk); #1;

      // timeout into ERROR
      for (int i = 0; i < 5; i++)
         cyc("tmo", 6'd1, 6'd2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle("err0");
      cyc("err1", 6'd5, 6'd0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("err_abs", 32'(mem_error), 32'd1);
      chk("err_en_abs", 32'(enable_pc), 32'd0);
      @(posedge clk); #1;

      // reset out of ERROR
      set_reset(1'b1);
      idle("rst_err");
      set_reset(1'b0);
      idle("post_err");

      // freeze overrides load-use
      cyc("pri0", 6'd5, 6'd0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("pri1", 6'd5, 6'd0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

      // asynchronous reset mid-wait
      set_reset(1'b1);
      cyc("rst_mid", 6'd5, 6'd0, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      set_reset(1'b0);
      idle("post_rst");
      @(negedge clk);
      chk("post_rst_cnt_abs", 32'(stall_cnt), 32'd0);
      @(posedge clk); #1;

      // random traffic
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 39) == 0) set_reset(1'b1);
         else set_reset(1'b0);
         cyc("rnd",
             6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
             6'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));
      end
      set_reset(1'b0);

      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_left got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage image-processing MIPS pipeline. Generates the `enable` inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the ID/EX bubble flush. It covers two cases: load-use hazards, and multi-cycle data-memory accesses with a `mem_ready` handshake and timeout. A 16-bit stall counter is provided for performance measurement.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of `MEM_WAIT` cycles before a memory fault; legal range 1..255.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rsD`  in  6  ID-stage source register 1.
- `rtD`  in  6  ID-stage source register 2.
- `WriteRegE`  in  6  EX-stage destination register.
- `RegWriteE`  in  1  EX-stage instruction writes the register file.
- `MemtoRegE`  in  1  EX-stage instruction is a load.
- `MemtoRegM`  in  1  MEM-stage instruction reads data memory.
- `MemWriteM`  in  1  MEM-stage instruction writes data memory.
- `mem_ready`  in  1  data memory completes the current access this cycle.
- `enable_pc`  out  1  PC register enable.
- `enable_if_id`  out  1  IF/ID register enable.
- `enable_id_ex`  out  1  ID/EX register enable.
- `enable_ex_mem`  out  1  EX/MEM register enable.
- `enable_mem_wb`  out  1  MEM/WB register enable.
- `flush_id_ex`  out  1  ID/EX loads a bubble (all control bits 0) on this edge.
- `mem_req`  out  1  data-memory access is pending.
- `mem_error`  out  1  sticky memory-timeout fault.
- `stall_cnt`  out  16  saturating count of stalled cycles.

## Operation
- **Signal definitions**
  - `mem_acc = MemtoRegM | MemWriteM`.
  - `lu_haz = RegWriteE & MemtoRegE & (WriteRegE != 0) & ((WriteRegE == rsD) | (WriteRegE == rtD))`.
  - Register 0 never causes a hazard.
- **FSM states:** `RUN`, `MEM_WAIT`, `ERROR`. Reset state is `RUN`.
- **Counters:** `wait_cnt` is 8 bits, reset 0.
- **Freeze condition:** `freeze = (state == RUN & mem_acc & !mem_ready) | (state == MEM_WAIT & !mem_ready)`.
- **Outputs** are combinational from state and inputs, applied in this priority order:
  1. `reset` high: all enables 0, `flush_id_ex` 0, `mem_req` 0.
  2. `ERROR`: all enables 0, `flush_id_ex` 0, `mem_req` 0, `mem_error` 1.
  3. `freeze`: all five enables 0, `flush_id_ex` 0. The memory freeze overrides load-use; no bubble is inserted while frozen.
  4. `lu_haz`: `enable_pc` = 0, `enable_if_id` = 0, `enable_id_ex` = 1, `flush_id_ex` = 1, `enable_ex_mem` = 1, `enable_mem_wb` = 1.
  5. Otherwise: all enables 1, `flush_id_ex` 0.
- **`mem_req`** = `mem_acc` in `RUN` or `MEM_WAIT` (reset and `ERROR` force it to 0).
- **Transitions**
  - `RUN` → `MEM_WAIT` when `mem_acc & !mem_ready`; set `wait_cnt` to 1.
  - `MEM_WAIT` → `RUN` when `mem_ready`; clear `wait_cnt` to 0.
  - `MEM_WAIT` → `ERROR` when `!mem_ready & wait_cnt == MEM_TIMEOUT`.
  - `MEM_WAIT`, otherwise: stay and increment `wait_cnt`.
  - `ERROR` is left only by `reset`.
- **`mem_error`** is registered: set on entry to `ERROR`, reset 0.
- **`stall_cnt`**
  - Increments by 1 on each edge where `enable_pc` was 0 and state was not `ERROR`.
  - Holds at 0xFFFF (no wrap).
  - Reset value 0.

## Timing
- Hazard detection has zero latency: enables respond in the same cycle as the inputs.
- **Load-use:** exactly one stall cycle per hazard. On the next edge the load has advanced to MEM, so `lu_haz` deasserts naturally.
- **Memory access, ready on first cycle:** zero stall.
- **Memory access, ready after k not-ready cycles:**
  - k frozen cycles.
  - The access completes in the cycle `mem_ready` is high; enables are 1 that cycle.
- **Timeout:**
  - Exactly `MEM_TIMEOUT + 1` consecutive frozen cycles precede entry to `ERROR`.
  - `mem_error` is visible in the following cycle.
- **`mem_ready` on the timeout cycle:** if `mem_ready` rises in the same cycle that `wait_cnt == MEM_TIMEOUT`, the state returns to `RUN`. Ready wins over the timeout.
- **`mem_ready` with no access:** when `mem_acc` = 0, `mem_ready` is ignored.
- **Reset asserted mid-`MEM_WAIT` or in `ERROR`:**
  - State goes to `RUN` immediately (asynchronous).
  - `wait_cnt` = 0, `mem_error` = 0, `stall_cnt` = 0.
- **Deassertion of `reset`:** takes effect at the next edge; the first post-reset cycle behaves as `RUN`.

## Test plan
- **Load-use hazard:** `RegWriteE` = 1, `MemtoRegE` = 1, `WriteRegE` = 5, `rsD` = 5, no memory access → one cycle with `enable_pc`/`enable_if_id` = 0 and `flush_id_ex` = 1; `stall_cnt` goes 0 → 1.
- **Register 0 hazard:** same stimulus with `WriteRegE` = 0 and `rtD` = 0 → no stall; all enables 1; `stall_cnt` stays 0.
- **Memory wait:** `MemtoRegM` = 1, `mem_ready` low for 3 cycles then high → 3 cycles with all enables 0 and `mem_req` = 1, then enables 1; state back in `RUN`; `stall_cnt` = 3.
- **Timeout:** `MEM_TIMEOUT` = 4, `MemWriteM` = 1, `mem_ready` held 0 → 5 frozen cycles, then `ERROR`; `mem_error` = 1 and all enables 0 persist until `reset`.
- **Ready on the boundary cycle:** `MEM_TIMEOUT` = 4, `mem_ready` rises exactly on the 5th not-ready-counting cycle (`wait_cnt` = 4) → returns to `RUN`; `mem_error` stays 0.
- **Priority and reset:** `lu_haz` and a pending memory wait together → freeze only, `flush_id_ex` = 0. Then assert `reset` mid-wait → enables 0 immediately; after release, `RUN` with `stall_cnt` = 0.
